// File: rtl/intf_pkg.sv
// Shared state encoding, byte size and sizing helpers for the UART-to-ALU interface.
package intf_pkg;

  localparam int SIZEBYTE = 8;

  typedef enum logic [5:0] {
    ST_OPA     = 6'b000001,
    ST_OPB     = 6'b000010,
    ST_OPCODE  = 6'b000100,
    ST_EXEC    = 6'b001000,
    ST_SEND    = 6'b010000,
    ST_WAIT_TX = 6'b100000
  } state_e;

  function automatic int nbytes(input int width);
    return (width + SIZEBYTE - 1) / SIZEBYTE;
  endfunction

  // Counter width able to index n values, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intf_tx_serializer.sv
// Sends a latched result to the UART transmitter one byte at a time, little-endian,
// using a start/done handshake; pulses o_done when the last byte is acknowledged.
module intf_tx_serializer
  import intf_pkg::*;
#(
  parameter int SIZEDATA = 16
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_load,
  input  logic [SIZEDATA-1:0] i_result,
  input  logic                i_tx_done,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_start,
  output logic                o_done
);

  localparam int NBYTES = nbytes(SIZEDATA);
  localparam int IDX_W  = clog2_min1(NBYTES);

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_e;

  tx_state_e           state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SIZEDATA-1:0] result_q, result_d;
  logic [7:0]          data_q, data_d;
  logic                start_q, start_d;

  // Bits above SIZEDATA in the top byte read as zero.
  function automatic logic [7:0] byte_of(input logic [SIZEDATA-1:0] word, input int sel);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < SIZEBYTE; i++)
      if (sel * SIZEBYTE + i < SIZEDATA) b[i] = word[sel*SIZEBYTE+i];
    return b;
  endfunction

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    data_d   = data_q;
    start_d  = 1'b0;
    o_done   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (i_load) begin
          result_d = i_result;
          idx_d    = '0;
          data_d   = byte_of(i_result, 0);
          start_d  = 1'b1;
          state_d  = TX_SEND;
        end
      end
      TX_SEND: state_d = TX_WAIT;
      TX_WAIT: begin
        if (i_tx_done) begin
          if (int'(idx_q) < NBYTES - 1) begin
            idx_d   = idx_q + IDX_W'(1);
            data_d  = byte_of(result_q, int'(idx_q) + 1);
            start_d = 1'b1;
            state_d = TX_SEND;
          end else begin
            idx_d   = '0;
            o_done  = 1'b1;
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= TX_IDLE;
      idx_q    <= '0;
      result_q <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      data_q   <= data_d;
      start_q  <= start_d;
    end
  end

  assign o_tx_data  = data_q;
  assign o_tx_start = start_q;

endmodule

// File: rtl/alu_uart_intf_mb.sv
// UART-to-ALU bridge: assembles multi-byte operands A, B and an opcode, waits the ALU latency,
// then returns the result bytewise. Inter-byte timeout is built only with `define INTF_TIMEOUT_EN.
module alu_uart_intf_mb
  import intf_pkg::*;
#(
  parameter int SIZEDATA       = 16,
  parameter int SIZEOP         = 6,
  parameter int ALU_LATENCY    = 0,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_rx_done,
  input  logic [7:0]          i_rx_data,
  input  logic [SIZEDATA-1:0] i_alu_result,
  input  logic                i_tx_done,
  output logic [SIZEDATA-1:0] o_alu_datoa,
  output logic [SIZEDATA-1:0] o_alu_datob,
  output logic [SIZEOP-1:0]   o_alu_opcode,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_start,
  output logic                o_busy,
  output logic                o_overrun,
  output logic                o_timeout
);

  localparam int NBYTES = nbytes(SIZEDATA);
  localparam int CNT_W  = clog2_min1(NBYTES);
  localparam int LAT_W  = clog2_min1(ALU_LATENCY + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [SIZEDATA-1:0] opa_q, opa_d;
  logic [SIZEDATA-1:0] opb_q, opb_d;
  logic [SIZEOP-1:0]   opc_q, opc_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;
  logic                ser_load, ser_done;
  logic                busy, last_byte;

  function automatic logic [SIZEDATA-1:0] put_byte(input logic [SIZEDATA-1:0] word,
                                                   input int sel, input logic [7:0] b);
    logic [SIZEDATA-1:0] w;
    w = word;
    for (int i = 0; i < SIZEDATA; i++)
      if (i / SIZEBYTE == sel) w[i] = b[i%SIZEBYTE];
    return w;
  endfunction

  assign busy      = (state_q == ST_EXEC) || (state_q == ST_SEND) || (state_q == ST_WAIT_TX);
  assign last_byte = (cnt_q == CNT_W'(NBYTES - 1));

`ifdef INTF_TIMEOUT_EN
  localparam int TO_W = clog2_min1(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            frame_q, frame_d;
  logic            in_rx_phase;

  assign in_rx_phase = (state_q == ST_OPA) || (state_q == ST_OPB) || (state_q == ST_OPCODE);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    opc_d     = opc_q;
    overrun_d = overrun_q;
    timeout_d = 1'b0;
    ser_load  = 1'b0;
    if (i_rx_done && busy) overrun_d = 1'b1;
    case (state_q)
      ST_OPA: begin
        if (i_rx_done) begin
          opa_d = put_byte(opa_q, int'(cnt_q), i_rx_data);
          if (cnt_q == '0) overrun_d = 1'b0;
          if (last_byte) begin
            cnt_d   = '0;
            state_d = ST_OPB;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_OPB: begin
        if (i_rx_done) begin
          opb_d = put_byte(opb_q, int'(cnt_q), i_rx_data);
          if (last_byte) begin
            cnt_d   = '0;
            state_d = ST_OPCODE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_OPCODE: begin
        if (i_rx_done) begin
          opc_d   = i_rx_data[SIZEOP-1:0];
          lat_d   = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (lat_q == LAT_W'(ALU_LATENCY)) begin
          ser_load = 1'b1;
          cnt_d    = '0;
          state_d  = ST_SEND;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_SEND: state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (ser_done)       state_d = ST_OPA;
        else if (i_tx_done) state_d = ST_SEND;
      end
      default: state_d = ST_OPA;
    endcase

`ifdef INTF_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    frame_d  = frame_q;
    if (i_rx_done) begin
      to_cnt_d = '0;
      // Accepting the opcode completes the frame, so the watchdog stops there.
      if (in_rx_phase) frame_d = (state_q != ST_OPCODE);
    end else if (in_rx_phase && frame_q) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = ST_OPA;
        cnt_d     = '0;
        timeout_d = 1'b1;
        frame_d   = 1'b0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_OPA;
      cnt_q     <= '0;
      lat_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      opc_q     <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      opc_q     <= opc_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef INTF_TIMEOUT_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      to_cnt_q <= '0;
      frame_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      frame_q  <= frame_d;
    end
  end
`endif

  intf_tx_serializer #(.SIZEDATA(SIZEDATA)) u_tx_ser (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (ser_load),
    .i_result   (i_alu_result),
    .i_tx_done  (i_tx_done),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_done     (ser_done)
  );

  assign o_alu_datoa  = opa_q;
  assign o_alu_datob  = opb_q;
  assign o_alu_opcode = opc_q;
  assign o_busy       = busy;
  assign o_overrun    = overrun_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_alu_uart_intf_mb.sv
// Directed bench for alu_uart_intf_mb: three instances cover 16-bit/latency 0, latency 3 and 12-bit widths.
module tb_alu_uart_intf_mb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rx_done [3];
  logic [7:0]  rx_data [3];
  logic        tx_done [3];
  logic [15:0] res1;
  logic [11:0] res2;

  wire [15:0] datoa [3];
  wire [15:0] datob [3];
  wire [5:0]  opcode [3];
  wire [7:0]  tx_data [3];
  wire        tx_start [3];
  wire        busy [3];
  wire        overrun [3];
  wire        timeout [3];
  wire [11:0] a12, b12;
  wire [15:0] res0 = datoa[0] + datob[0];

  assign datoa[2] = {4'h0, a12};
  assign datob[2] = {4'h0, b12};

  int checks = 0;
  int errors = 0;

  alu_uart_intf_mb #(.SIZEDATA(16), .SIZEOP(6), .ALU_LATENCY(0)
`ifdef INTF_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) u_dut0 (
    .i_clock(clk), .i_reset(rst), .i_rx_done(rx_done[0]), .i_rx_data(rx_data[0]),
    .i_alu_result(res0), .i_tx_done(tx_done[0]), .o_alu_datoa(datoa[0]), .o_alu_datob(datob[0]),
    .o_alu_opcode(opcode[0]), .o_tx_data(tx_data[0]), .o_tx_start(tx_start[0]), .o_busy(busy[0]),
    .o_overrun(overrun[0]), .o_timeout(timeout[0])
  );

  alu_uart_intf_mb #(.SIZEDATA(16), .SIZEOP(6), .ALU_LATENCY(3)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_rx_done(rx_done[1]), .i_rx_data(rx_data[1]),
    .i_alu_result(res1), .i_tx_done(tx_done[1]), .o_alu_datoa(datoa[1]), .o_alu_datob(datob[1]),
    .o_alu_opcode(opcode[1]), .o_tx_data(tx_data[1]), .o_tx_start(tx_start[1]), .o_busy(busy[1]),
    .o_overrun(overrun[1]), .o_timeout(timeout[1])
  );

  alu_uart_intf_mb #(.SIZEDATA(12), .SIZEOP(6), .ALU_LATENCY(0)) u_dut2 (
    .i_clock(clk), .i_reset(rst), .i_rx_done(rx_done[2]), .i_rx_data(rx_data[2]),
    .i_alu_result(res2), .i_tx_done(tx_done[2]), .o_alu_datoa(a12), .o_alu_datob(b12),
    .o_alu_opcode(opcode[2]), .o_tx_data(tx_data[2]), .o_tx_start(tx_start[2]), .o_busy(busy[2]),
    .o_overrun(overrun[2]), .o_timeout(timeout[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input int d, input logic [7:0] b);
    @(negedge clk);
    rx_data[d] = b;
    rx_done[d] = 1'b1;
    @(negedge clk);
    rx_done[d] = 1'b0;
  endtask

  task automatic tx_ack(input int d);
    @(negedge clk);
    tx_done[d] = 1'b1;
    @(negedge clk);
    tx_done[d] = 1'b0;
  endtask

  // Returns cycles from the opcode rx_done to the first tx_start, or -1 if none within budget.
  task automatic wait_start(input int d, input int set_at, output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == set_at) res1 = 16'hBEEF;
      if (tx_start[d] === 1'b1) begin
        lat = n + 1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int pulses;
    for (int i = 0; i < 3; i++) begin
      rx_done[i] = 1'b0;
      rx_data[i] = 8'h00;
      tx_done[i] = 1'b0;
    end
    res1 = 16'h0000;
    res2 = 12'hABC;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_datoa", datoa[0], 0);
    check("rst_opcode", opcode[0], 0);
    check("rst_tx", {tx_data[0], tx_start[0], busy[0], overrun[0], timeout[0]}, 0);
    check("rst_dut2", {datoa[2], tx_data[2], busy[2]}, 0);
    rst = 1'b0;

    // Frame 1: A=0x1234, B=0x0002, A+B=0x1236
    send_byte(0, 8'h34); send_byte(0, 8'h12);
    send_byte(0, 8'h02); send_byte(0, 8'h00);
    send_byte(0, 8'h20);
    check("f1_datoa", datoa[0], 16'h1234);
    check("f1_datob", datob[0], 16'h0002);
    check("f1_opcode", opcode[0], 6'h20);
    check("f1_busy_exec", busy[0], 1'b1);
    wait_start(0, -1, lat);
    check("f1_latency", lat, 2);
    check("f1_byte0", tx_data[0], 8'h36);
    @(negedge clk);
    check("f1_start_pulse", tx_start[0], 1'b0);
    check("f1_hold", tx_data[0], 8'h36);
    tx_ack(0);
    check("f1_start1", tx_start[0], 1'b1);
    check("f1_byte1", tx_data[0], 8'h12);
    tx_ack(0);
    check("f1_idle", {busy[0], tx_start[0]}, 2'b00);

    // Frame 2 with bytes arriving while transmitting
    send_byte(0, 8'h01); send_byte(0, 8'h00);
    send_byte(0, 8'h01); send_byte(0, 8'h00);
    send_byte(0, 8'h05);
    wait_start(0, -1, lat);
    check("f2_byte0", tx_data[0], 8'h02);
    send_byte(0, 8'h55);
    check("ovr_set", overrun[0], 1'b1);
    check("ovr_not_stored", datoa[0], 16'h0001);
    check("ovr_still_wait", {busy[0], tx_start[0]}, 2'b10);
    tx_ack(0);
    check("f2_byte1", {tx_start[0], tx_data[0]}, 9'h100);
    @(negedge clk);
    rx_data[0] = 8'h77; rx_done[0] = 1'b1; tx_done[0] = 1'b1;
    @(negedge clk);
    rx_done[0] = 1'b0; tx_done[0] = 1'b0;
    check("simul_done", busy[0], 1'b0);
    check("simul_ovr", overrun[0], 1'b1);
    check("simul_dropped", datoa[0], 16'h0001);

    send_byte(0, 8'hAA);
    check("ovr_clear", overrun[0], 1'b0);
    check("f3_a0", datoa[0], 16'h00AA);
    send_byte(0, 8'hBB);
    send_byte(0, 8'h11);
    check("f3_b0", datob[0], 16'h0011);

    // Asynchronous reset between B bytes, away from any clock edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ops", {datoa[0], datob[0], 2'b00, opcode[0]}, 0);
    check("arst_flags", {busy[0], overrun[0], tx_start[0], tx_data[0]}, 0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(0, 8'h11); send_byte(0, 8'h22);
    send_byte(0, 8'h33); send_byte(0, 8'h44);
    send_byte(0, 8'h07);
    check("f4_ops", {datoa[0], datob[0]}, 32'h2211_4433);
    wait_start(0, -1, lat);
    check("f4_latency", lat, 2);
    check("f4_byte0", tx_data[0], 8'h44);
    tx_ack(0);
    check("f4_byte1", tx_data[0], 8'h66);
    tx_ack(0);
    check("f4_idle", busy[0], 1'b0);

    // ALU latency 3: result appears late and must be latched on the last EXEC cycle
    for (int i = 0; i < 5; i++) send_byte(1, 8'h01);
    wait_start(1, 3, lat);
    check("lat3_latency", lat, 5);
    check("lat3_byte0", tx_data[1], 8'hEF);
    tx_ack(1);
    check("lat3_byte1", tx_data[1], 8'hBE);
    tx_ack(1);
    check("lat3_idle", busy[1], 1'b0);

    // 12-bit operands: top-byte bits discarded on RX, zero-padded on TX
    send_byte(2, 8'hFF); send_byte(2, 8'hFF);
    send_byte(2, 8'h00); send_byte(2, 8'h00);
    send_byte(2, 8'hC3);
    check("w12_datoa", datoa[2], 16'h0FFF);
    check("w12_opcode", opcode[2], 6'h03);
    wait_start(2, -1, lat);
    check("w12_byte0", tx_data[2], 8'hBC);
    tx_ack(2);
    check("w12_byte1", tx_data[2], 8'h0A);
    tx_ack(2);
    check("w12_idle", busy[2], 1'b0);

    // Partial frame left idle
    send_byte(0, 8'h99);
    check("to_a0", datoa[0], 16'h2299);
    pulses = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (timeout[0] === 1'b1) pulses++;
    end
    send_byte(0, 8'h5A);
`ifdef INTF_TIMEOUT_EN
    check("to_pulses", pulses, 1);
    check("to_restart", datoa[0], 16'h225A);
`else
    check("to_pulses", pulses, 0);
    check("to_continue", datoa[0], 16'h5A99);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
